dsram_axi_bridge: RTL and testbench

//  Converts the core's single-cycle data_sram port into single-beat AXI3 master transactions, one outstanding at a time.

---
 rtl/dsram_axi_bridge_pkg.sv | 23 ++
 rtl/dsram_axi_bridge.sv | 156 +++++++++++++++
 tb/tb_dsram_axi_bridge.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsram_axi_bridge_pkg.sv
// Shared types and AXI constants for the data_sram-to-AXI bridge.
// The bridge issues only single-beat, 4-byte INCR transfers.
package dsram_axi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // States in which the core must hold regardless of data_sram_en.
  function automatic logic busy_state(input state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/dsram_axi_bridge.sv
// Turns the core's single-cycle data_sram port into one-outstanding, single-beat
// AXI3 reads/writes, stalling the pipeline until the transfer completes.
module dsram_axi_bridge
  import dsram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  data_sram_en,
  input  logic [DATA_W/8-1:0]   data_sram_wen,
  input  logic [ADDR_W-1:0]     data_sram_addr,
  input  logic [DATA_W-1:0]     data_sram_wdata,
  output logic [DATA_W-1:0]     data_sram_rdata,
  output logic                  stallreq_for_mem,

  output logic [3:0]            arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [3:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,

  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,

  output logic [3:0]            awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [3:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,

  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,

  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int STRB_W = DATA_W / 8;

  state_t              state;
  logic [ADDR_W-1:0]   req_addr_p0;
  logic [STRB_W-1:0]   req_wen_p0;
  logic [DATA_W-1:0]   req_wdata_p0;
  logic                capture;

  // Responses are single-beat and error codes are not reported to the core.
  logic unused_inputs;
  assign unused_inputs = ^{data_sram_addr[1:0], rresp, rlast, bresp};

  assign capture = (state == IDLE) && data_sram_en;

  // Capture stage: request payload is held here so AXI payload stays stable.
  always_ff @(posedge clk) begin
    if (capture) begin
      req_addr_p0  <= {data_sram_addr[ADDR_W-1:2], 2'b00};
      req_wen_p0   <= data_sram_wen;
      req_wdata_p0 <= data_sram_wdata;
    end
  end

  assign arid    = AXI_ID;
  assign araddr  = req_addr_p0;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;

  assign awid    = AXI_ID;
  assign awaddr  = req_addr_p0;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = AXI_SIZE_4B;
  assign awburst = AXI_BURST_INCR;

  assign wdata   = req_wdata_p0;
  assign wstrb   = req_wen_p0;
  assign wlast   = 1'b1;

  // The capture cycle stalls combinationally so the core never advances past a new request.
  assign stallreq_for_mem = busy_state(state) || capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      arvalid         <= 1'b0;
      rready          <= 1'b0;
      awvalid         <= 1'b0;
      wvalid          <= 1'b0;
      bready          <= 1'b0;
      data_sram_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (data_sram_en) begin
            if (|data_sram_wen) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_REQ;
            end else begin
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready          <= 1'b0;
            data_sram_rdata <= rdata;
            state           <= DONE;
          end
        end
        WR_REQ: begin
          // AW and W retire independently; leave once neither is still pending.
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          // en here is still the request just served, so it is not re-captured.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsram_axi_bridge.sv
// Self-checking bench for dsram_axi_bridge: a core driver and AXI slave with
// programmable latencies, checked against transaction-level expectations.
module tb_dsram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        stallreq_for_mem;
  logic [3:0]  arid, arlen, awid, awlen;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  dsram_axi_bridge dut (
    .clk(clk), .rst(rst),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .stallreq_for_mem(stallreq_for_mem),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd;   // model of the value the core should see after any access

  // Observations of the most recent transaction
  int          ob_stall, ob_cycles, ob_ar, ob_r, ob_aw, ob_w, ob_b, ob_unstable, ob_badready;
  bit          ob_timeout, ob_nostall0;
  logic [31:0] ob_araddr, ob_awaddr, ob_wdata, ob_done_rdata;
  logic [3:0]  ob_wstrb, ob_arid, ob_awid, ob_arlen, ob_awlen;
  logic [2:0]  ob_arsize, ob_awsize;
  logic [1:0]  ob_arburst, ob_awburst;
  logic        ob_wlast;

  task automatic clear_slave();
    arready = 0; rvalid = 0; rdata = 0; rlast = 0;
    awready = 0; wready = 0; bvalid = 0;
  endtask

  // Core issues one request and holds it while stalled; slave answers with given latencies.
  task automatic do_txn(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wd,
                        input logic [31:0] rd_resp, input int ar_dly, input int r_dly,
                        input int aw_dly, input int w_dly, input int b_dly, input bit keep_en);
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit ar_done, r_done, aw_done, w_done, b_done, finished;
    bit ar_pend, aw_pend, w_pend;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    ar_done = 0; r_done = 0; aw_done = 0; w_done = 0; b_done = 0; finished = 0;
    ar_pend = 0; aw_pend = 0; w_pend = 0;
    p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_wstrb = 0;
    ob_stall = 0; ob_cycles = -1; ob_ar = 0; ob_r = 0; ob_aw = 0; ob_w = 0; ob_b = 0;
    ob_unstable = 0; ob_badready = 0; ob_timeout = 0; ob_nostall0 = 0;
    ob_araddr = 'x; ob_awaddr = 'x; ob_wdata = 'x; ob_wstrb = 'x; ob_wlast = 'x; ob_done_rdata = 'x;
    @(negedge clk);
    data_sram_en = 1; data_sram_wen = wen; data_sram_addr = addr; data_sram_wdata = wd;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      #1;
      if (cyc == 0 && !stallreq_for_mem) ob_nostall0 = 1;
      if (ar_pend && (!arvalid || araddr !== p_araddr)) ob_unstable++;
      if (aw_pend && (!awvalid || awaddr !== p_awaddr)) ob_unstable++;
      if (w_pend && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) ob_unstable++;
      if (rready && !(ar_done && !r_done)) ob_badready++;
      if (bready && !(aw_done && w_done && !b_done)) ob_badready++;
      if (cyc > 0 && !stallreq_for_mem) begin
        finished = 1;
        ob_cycles = cyc;
        ob_done_rdata = data_sram_rdata;
        if (!keep_en) data_sram_en = 0;
      end else begin
        if (stallreq_for_mem) ob_stall++;
        arready = arvalid && (ar_cnt >= ar_dly);
        rvalid  = ar_done && !r_done && (r_cnt >= r_dly);
        rdata   = rvalid ? rd_resp : $urandom;
        rlast   = rvalid;
        awready = awvalid && (aw_cnt >= aw_dly);
        wready  = wvalid && (w_cnt >= w_dly);
        bvalid  = aw_done && w_done && !b_done && (b_cnt >= b_dly);
        if (arvalid && arready) begin
          ob_ar++; ob_araddr = araddr; ob_arid = arid; ob_arlen = arlen;
          ob_arsize = arsize; ob_arburst = arburst;
        end
        if (rvalid && rready) ob_r++;
        if (awvalid && awready) begin
          ob_aw++; ob_awaddr = awaddr; ob_awid = awid; ob_awlen = awlen;
          ob_awsize = awsize; ob_awburst = awburst;
        end
        if (wvalid && wready) begin
          ob_w++; ob_wdata = wdata; ob_wstrb = wstrb; ob_wlast = wlast;
        end
        if (bvalid && bready) ob_b++;
        ar_pend = arvalid && !arready; p_araddr = araddr;
        aw_pend = awvalid && !awready; p_awaddr = awaddr;
        w_pend  = wvalid && !wready;   p_wdata = wdata; p_wstrb = wstrb;
        if (arvalid) ar_cnt++;
        if (ar_done) r_cnt++;
        if (awvalid) aw_cnt++;
        if (wvalid)  w_cnt++;
        if (aw_done && w_done) b_cnt++;
        ar_done = ar_done || (arvalid && arready);
        r_done  = r_done  || (rvalid && rready);
        aw_done = aw_done || (awvalid && awready);
        w_done  = w_done  || (wvalid && wready);
        b_done  = b_done  || (bvalid && bready);
        @(negedge clk);
      end
    end
    clear_slave();
    if (!finished) begin
      ob_timeout = 1;
      rst = 1; data_sram_en = 0;
      @(negedge clk);
      rst = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1; data_sram_en = 0; data_sram_wen = 0; data_sram_addr = 0; data_sram_wdata = 0;
    rresp = 0; bresp = 0; clear_slave();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (stallreq_for_mem !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stallreq_for_mem); end
    checks++; if ({arvalid, awvalid, wvalid} !== 3'b000) begin errors++; $display("FAIL reset_valids: got %b want 000", {arvalid, awvalid, wvalid}); end
    checks++; if ({rready, bready} !== 2'b00) begin errors++; $display("FAIL reset_readies: got %b want 00", {rready, bready}); end
    checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", data_sram_rdata); end
    rst = 0;
    last_rd = 0;
  endtask

  task automatic test_read();
    do_txn(32'h1000_0006, 4'b0000, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
    last_rd = 32'hDEAD_BEEF;
    checks++; if (ob_timeout !== 1'b0) begin errors++; $display("FAIL read_timeout: got %b want 0", ob_timeout); end
    checks++; if (ob_araddr !== 32'h1000_0004) begin errors++; $display("FAIL read_araddr: got %h want 10000004", ob_araddr); end
    checks++; if (ob_done_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata: got %h want deadbeef", ob_done_rdata); end
    checks++; if (ob_stall !== 3) begin errors++; $display("FAIL read_stall_cycles: got %0d want 3", ob_stall); end
    checks++; if (ob_cycles !== 3) begin errors++; $display("FAIL read_done_cycle: got %0d want 3", ob_cycles); end
    checks++; if (ob_nostall0 !== 1'b0) begin errors++; $display("FAIL read_capture_stall: got %b want 0", ob_nostall0); end
    checks++; if ({ob_arid, ob_arlen, ob_arsize, ob_arburst} !== {4'd1, 4'd0, 3'b010, 2'b01})
      begin errors++; $display("FAIL read_ar_attrs: got %h want %h", {ob_arid, ob_arlen, ob_arsize, ob_arburst}, {4'd1, 4'd0, 3'b010, 2'b01}); end
    checks++; if ({ob_ar, ob_r, ob_aw} !== {32'd1, 32'd1, 32'd0}) begin errors++; $display("FAIL read_hs_count: got ar=%0d r=%0d aw=%0d want 1 1 0", ob_ar, ob_r, ob_aw); end
  endtask

  task automatic test_write();
    do_txn(32'h2000_000A, 4'b0011, 32'h0000_1234, 32'h0, 0, 0, 0, 0, 0, 0);
    checks++; if (ob_awaddr !== 32'h2000_0008) begin errors++; $display("FAIL write_awaddr: got %h want 20000008", ob_awaddr); end
    checks++; if (ob_wstrb !== 4'b0011) begin errors++; $display("FAIL write_wstrb: got %b want 0011", ob_wstrb); end
    checks++; if (ob_wlast !== 1'b1) begin errors++; $display("FAIL write_wlast: got %b want 1", ob_wlast); end
    checks++; if (ob_wdata !== 32'h0000_1234) begin errors++; $display("FAIL write_wdata: got %h want 00001234", ob_wdata); end
    checks++; if (ob_cycles !== 3) begin errors++; $display("FAIL write_done_cycle: got %0d want 3", ob_cycles); end
    checks++; if (ob_done_rdata !== last_rd) begin errors++; $display("FAIL write_rdata_held: got %h want %h", ob_done_rdata, last_rd); end
    checks++; if ({ob_awid, ob_awlen, ob_awsize, ob_awburst} !== {4'd1, 4'd0, 3'b010, 2'b01})
      begin errors++; $display("FAIL write_aw_attrs: got %h want %h", {ob_awid, ob_awlen, ob_awsize, ob_awburst}, {4'd1, 4'd0, 3'b010, 2'b01}); end
    do_txn(32'h2000_0100, 4'b0100, 32'h00AB_0000, 32'h0, 0, 0, 0, 0, 4, 0);
    checks++; if (ob_cycles !== 7) begin errors++; $display("FAIL write_bwait_done_cycle: got %0d want 7", ob_cycles); end
    checks++; if (ob_b !== 1) begin errors++; $display("FAIL write_b_count: got %0d want 1", ob_b); end
  endtask

  task automatic test_write_order();
    int aw_d[3] = '{3, 0, 2};
    int w_d[3]  = '{1, 2, 2};
    for (int i = 0; i < 3; i++) begin
      do_txn(32'h3000_0040 + 32'(i * 4), 4'b1111, 32'hC0DE_0000 + 32'(i), 32'h0, 0, 0, aw_d[i], w_d[i], 1, 0);
      checks++; if ({ob_aw, ob_w} !== {32'd1, 32'd1}) begin errors++; $display("FAIL order%0d_reissue: got aw=%0d w=%0d want 1 1", i, ob_aw, ob_w); end
      checks++; if (ob_badready !== 0) begin errors++; $display("FAIL order%0d_early_bready: got %0d want 0", i, ob_badready); end
      checks++; if (ob_unstable !== 0) begin errors++; $display("FAIL order%0d_stable: got %0d want 0", i, ob_unstable); end
      checks++; if (ob_cycles !== 1 + (((aw_d[i] > w_d[i]) ? aw_d[i] : w_d[i]) + 1) + 2)
        begin errors++; $display("FAIL order%0d_done_cycle: got %0d want %0d", i, ob_cycles, 1 + (((aw_d[i] > w_d[i]) ? aw_d[i] : w_d[i]) + 1) + 2); end
    end
  endtask

  task automatic test_ar_stall();
    do_txn(32'h4000_0013, 4'b0000, 32'h0, 32'h5A5A_A5A5, 5, 0, 0, 0, 0, 0);
    last_rd = 32'h5A5A_A5A5;
    checks++; if (ob_unstable !== 0) begin errors++; $display("FAIL arwait_stable: got %0d want 0", ob_unstable); end
    checks++; if (ob_stall !== 8) begin errors++; $display("FAIL arwait_stall_cycles: got %0d want 8", ob_stall); end
    checks++; if (ob_araddr !== 32'h4000_0010) begin errors++; $display("FAIL arwait_araddr: got %h want 40000010", ob_araddr); end
    checks++; if (ob_done_rdata !== 32'h5A5A_A5A5) begin errors++; $display("FAIL arwait_rdata: got %h want 5a5aa5a5", ob_done_rdata); end
  endtask

  task automatic test_back_to_back();
    do_txn(32'h5000_0000, 4'b0000, 32'h0, 32'h1357_9BDF, 0, 1, 0, 0, 0, 1);
    last_rd = 32'h1357_9BDF;
    checks++; if (ob_ar !== 1) begin errors++; $display("FAIL b2b_load_ar: got %0d want 1", ob_ar); end
    do_txn(32'h5000_0004, 4'b1000, 32'h7700_0000, 32'h0, 0, 0, 1, 0, 0, 0);
    checks++; if ({ob_ar, ob_aw} !== {32'd0, 32'd1}) begin errors++; $display("FAIL b2b_store_hs: got ar=%0d aw=%0d want 0 1", ob_ar, ob_aw); end
    checks++; if (ob_done_rdata !== last_rd) begin errors++; $display("FAIL b2b_rdata_held: got %h want %h", ob_done_rdata, last_rd); end
    checks++; if (ob_cycles !== 4) begin errors++; $display("FAIL b2b_store_done_cycle: got %0d want 4", ob_cycles); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd;
    logic [3:0]  wen;
    int ard, rdd, awd, wdd, bd, exp_cyc;
    bit keep;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; wd = $urandom; rd = $urandom;
      wen = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      ard = $urandom_range(0, 3); rdd = $urandom_range(0, 3);
      awd = $urandom_range(0, 3); wdd = $urandom_range(0, 3); bd = $urandom_range(0, 3);
      keep = ($urandom_range(0, 1) == 1);
      do_txn(a, wen, wd, rd, ard, rdd, awd, wdd, bd, keep);
      if (wen == 0) begin
        last_rd = rd;
        exp_cyc = 1 + (ard + 1) + (rdd + 1);
        checks++; if (ob_araddr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL rnd%0d_araddr: got %h want %h", i, ob_araddr, {a[31:2], 2'b00}); end
        checks++; if ({ob_ar, ob_r, ob_aw, ob_w} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin errors++; $display("FAIL rnd%0d_rd_hs: got %0d %0d %0d %0d want 1 1 0 0", i, ob_ar, ob_r, ob_aw, ob_w); end
      end else begin
        exp_cyc = 1 + (((awd > wdd) ? awd : wdd) + 1) + (bd + 1);
        checks++; if ({ob_awaddr, ob_wdata, ob_wstrb} !== {a[31:2], 2'b00, wd, wen})
          begin errors++; $display("FAIL rnd%0d_wr_payload: got %h %h %b want %h %h %b", i, ob_awaddr, ob_wdata, ob_wstrb, {a[31:2], 2'b00}, wd, wen); end
        checks++; if ({ob_ar, ob_aw, ob_w, ob_b} !== {32'd0, 32'd1, 32'd1, 32'd1}) begin errors++; $display("FAIL rnd%0d_wr_hs: got %0d %0d %0d %0d want 0 1 1 1", i, ob_ar, ob_aw, ob_w, ob_b); end
      end
      checks++; if (ob_cycles !== exp_cyc) begin errors++; $display("FAIL rnd%0d_done_cycle: got %0d want %0d", i, ob_cycles, exp_cyc); end
      checks++; if (ob_done_rdata !== last_rd) begin errors++; $display("FAIL rnd%0d_rdata: got %h want %h", i, ob_done_rdata, last_rd); end
      checks++; if (ob_unstable + ob_badready !== 0) begin errors++; $display("FAIL rnd%0d_axi_rules: got unstable=%0d badready=%0d want 0 0", i, ob_unstable, ob_badready); end
    end
    @(negedge clk);
    data_sram_en = 0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_txn(32'h6000_0000, 4'b0000, 32'h0, 32'hFACE_CAFE, 0, 0, 0, 0, 0, 0);
    checks++; if (ob_done_rdata !== 32'hFACE_CAFE) begin errors++; $display("FAIL rstmid_pre_rdata: got %h want facecafe", ob_done_rdata); end
    @(negedge clk);
    data_sram_en = 1; data_sram_wen = 0; data_sram_addr = 32'h6000_0008;
    seen = 0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      #1;
      if (rready) seen = 1;
      else begin
        arready = arvalid;
        @(negedge clk);
      end
    end
    arready = 0; rvalid = 0;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rstmid_reach_rdata: got %b want 1", seen); end
    rst = 1; data_sram_en = 0;
    @(negedge clk);
    rst = 0;
    #1;
    last_rd = 0;
    checks++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin errors++; $display("FAIL rstmid_valids: got %b want 00000", {arvalid, awvalid, wvalid, rready, bready}); end
    checks++; if (stallreq_for_mem !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b want 0", stallreq_for_mem); end
    checks++; if (data_sram_rdata !== last_rd) begin errors++; $display("FAIL rstmid_rdata: got %h want %h", data_sram_rdata, last_rd); end
    @(negedge clk);
    #1;
    checks++; if ({stallreq_for_mem, rready, arvalid} !== 3'b000) begin errors++; $display("FAIL rstmid_idle_hold: got %b want 000", {stallreq_for_mem, rready, arvalid}); end
    do_txn(32'h6000_0024, 4'b0000, 32'h0, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 0);
    last_rd = 32'h0BAD_F00D;
    checks++; if (ob_done_rdata !== last_rd || ob_cycles !== 3) begin errors++; $display("FAIL rstmid_recover: got %h/%0d want %h/3", ob_done_rdata, ob_cycles, last_rd); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_write_order();
    test_ar_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
